// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and the angle-index wrap helper for the
// CORDIC sweep controller, the angle ROM and the CORDIC core.
package cordic_pkg;

  localparam int SZ                 = 16;
  localparam int N_ANGLES           = 360;
  localparam int ADDR_W             = 9;
  localparam int ROM_LAT_DEFAULT    = 1;
  localparam int CORDIC_LAT_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Add an increment to an angle index and fold back into 0..n-1.
  // Both operands are below n, so a single conditional subtract suffices.
  function automatic logic [ADDR_W-1:0] wrap_add(
    input logic [ADDR_W-1:0] a,
    input logic [ADDR_W-1:0] s,
    input logic [ADDR_W:0]   n
  );
    logic [ADDR_W:0] sum;
    sum = {1'b0, a} + {1'b0, s};
    if (sum >= n) begin
      sum = sum - n;
    end
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/cordic_sweep_ctrl_valid_pipe.sv
// Fixed-depth 1-bit delay line that tracks issued ROM addresses through the
// ROM + CORDIC latency. 'empty' means no valid will appear after this cycle.
module valid_pipe #(
  parameter int DEPTH = 17
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout,
  output logic empty
);

  logic [DEPTH-1:0] sr;

  // First stage captures the issue strobe.
  always_ff @(posedge clk) begin
    if (clr) begin
      sr[0] <= 1'b0;
    end else begin
      sr[0] <= din;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_stage
      // Each later stage shifts the previous one along.
      always_ff @(posedge clk) begin
        if (clr) begin
          sr[gi] <= 1'b0;
        end else begin
          sr[gi] <= sr[gi-1];
        end
      end
    end

    // Only the output stage may be occupied for the pipe to drain this cycle.
    if (DEPTH > 1) begin : g_empty_deep
      assign empty = ~din & ~|sr[DEPTH-2:0];
    end else begin : g_empty_short
      assign empty = ~din;
    end
  endgenerate

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/cordic_sweep_ctrl.sv
// Sweep controller: steps an angle-ROM index through the table at a
// programmable increment, tracks in-flight samples and flags completion.
module cordic_sweep_ctrl #(
  parameter int ROM_LAT    = cordic_pkg::ROM_LAT_DEFAULT,
  parameter int CORDIC_LAT = cordic_pkg::CORDIC_LAT_DEFAULT,
  parameter int N_ANGLES   = cordic_pkg::N_ANGLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic [cordic_pkg::ADDR_W-1:0] step,
  input  logic [15:0]                   n_samples,
  output logic [cordic_pkg::ADDR_W-1:0] addr,
  output logic                          sample_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err
);

  import cordic_pkg::*;

  localparam int              DEPTH    = ROM_LAT + CORDIC_LAT;
  localparam logic [ADDR_W:0] N_ANG_W  = (ADDR_W + 1)'(N_ANGLES);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   step_lat;
  logic [ADDR_W-1:0]   last_addr;
  logic [15:0]         remain;
  logic                cont;
  logic                issue;
  logic                last;
  logic                step_ok;
  logic                accept;
  logic                pipe_empty;

  assign step_ok = (step != '0) && ({1'b0, step} < N_ANG_W);
  assign accept  = (state == S_IDLE) && start && step_ok;
  // A bounded sweep ends on the issue that consumes its final count.
  assign last    = !cont && (remain == 16'd1);

  // Next-state and issue decode; stop in RUN takes priority over issuing.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && step_ok) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_next = S_DRAIN;
        end else begin
          issue = 1'b1;
          if (last) begin
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pipe_empty) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  // State register, sweep configuration, address stepping and error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      last_addr <= '0;
      step_lat  <= '0;
      remain    <= '0;
      cont      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state   <= state_next;
      cfg_err <= (state == S_IDLE) && start && !step_ok;
      if (accept) begin
        addr      <= '0;
        last_addr <= '0;
        step_lat  <= step;
        remain    <= n_samples;
        cont      <= (n_samples == 16'd0);
      end else if (issue) begin
        last_addr <= addr;
        remain    <= remain - 16'd1;
        // The final issued index stays on addr through DRAIN/DONE/IDLE.
        if (!last) begin
          addr <= wrap_add(addr, step_lat, N_ANG_W);
        end
      end else if (state == S_RUN) begin
        // Stop: addr already points at an unissued index, so roll it back.
        addr <= last_addr;
      end
    end
  end

  valid_pipe #(
    .DEPTH(DEPTH)
  ) u_valid_pipe (
    .clk  (clk),
    .clr  (!rst_n),
    .din  (issue),
    .dout (sample_valid),
    .empty(pipe_empty)
  );

endmodule
